fir_sum_reader: RTL and testbench

//  Read-side drain for fir_filter_core. Pops one filter result per handshake via the core's

---
 rtl/fir_sum_reader.sv | 150 +++++++++++++++
 tb/tb_fir_sum_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_sum_reader.sv
// fir_sum_reader: drains fir_filter_core results over its empty/read port, scales and
// saturates each sum, and offers it on a valid/ready port. Optional macro: FIR_READER_ROUND_EN.
module fir_sum_reader #(
  parameter int unsigned SUM_W    = 32,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned SHIFT    = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic             clk3,
  input  logic             reset,
  input  logic             enable,
  input  logic             empty,
  output logic             read,
  input  logic [SUM_W-1:0] sum,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      result_count,
  output logic             sat_flag
);

  localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int unsigned CNT_OUT_W = 16;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   read_q, read_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_W-1:0]       out_data_q, out_data_d;
  logic [CNT_OUT_W-1:0]   count_q, count_d;
  logic                   sat_q, sat_d;

  logic signed [SUM_W:0]  sum_ext;
  logic signed [SUM_W:0]  t_ext;
  logic [SUM_W-OUT_W+1:0] t_upper;
  logic                   fits;
  logic                   sat_pos;
  logic                   sat_neg;
  logic [OUT_W-1:0]       scaled;

`ifdef FIR_READER_ROUND_EN
  // Half-LSB bias; zero when SHIFT==0 so no rounding is applied.
  localparam logic signed [SUM_W:0] RND = ((SUM_W+1)'(1) << SHIFT) >> 1;
`endif

  // Shift at SUM_W+1 bits so the rounding add cannot wrap, then clamp to OUT_W.
  always_comb begin
    sum_ext = {sum[SUM_W-1], sum};
`ifdef FIR_READER_ROUND_EN
    t_ext   = (sum_ext + RND) >>> SHIFT;
`else
    t_ext   = sum_ext >>> SHIFT;
`endif
    t_upper = t_ext[SUM_W:OUT_W-1];
    fits    = (&t_upper) | ~(|t_upper);
    sat_pos = ~t_ext[SUM_W] & ~fits;
    sat_neg =  t_ext[SUM_W] & ~fits;
    if (sat_pos) begin
      scaled = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (sat_neg) begin
      scaled = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      scaled = t_ext[OUT_W-1:0];
    end
  end

  // State and output registers.
  always_ff @(posedge clk3) begin
    if (reset) begin
      state_q     <= S_IDLE;
      read_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
    end
  end

  // Next-state logic; a held result blocks further pops until accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable && !empty) state_d = S_POP;
      S_POP:  state_d = S_WAIT;
      S_WAIT: if (cnt_q == '0) state_d = S_HOLD;
      S_HOLD: if (out_valid_q && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values.
  always_comb begin
    read_d      = 1'b0;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    count_d     = count_q;
    sat_d       = sat_q;
    case (state_q)
      S_IDLE: begin
        if (enable && !empty) read_d = 1'b1;
      end
      S_POP: begin
        cnt_d = CNT_INIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          out_data_d  = scaled;
          out_valid_d = 1'b1;
          sat_d       = sat_q | sat_pos | sat_neg;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          count_d     = count_q + 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign read         = read_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign result_count = count_q;
  assign sat_flag     = sat_q;

endmodule

// File: tb/tb_fir_sum_reader.sv
// Scoreboard bench for fir_sum_reader: a small core model feeds sums, a forked monitor
// checks every accepted result against expected values queued at stimulus time.
module tb_fir_sum_reader;

  logic        clk3 = 1'b0;
  logic        reset;
  logic        enable;
  logic        empty;
  logic        read;
  logic [31:0] sum;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result_count;
  logic        sat_flag;

  int n_vec = 0;
  int n_err = 0;
  int read_cnt = 0;
  int r0;

  logic [31:0] pending[$];
  logic [15:0] exp_q[$];

  always #5 clk3 = ~clk3;

  fir_sum_reader dut (
    .clk3         (clk3),
    .reset        (reset),
    .enable       (enable),
    .empty        (empty),
    .read         (read),
    .sum          (sum),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_count (result_count),
    .sat_flag     (sat_flag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One cycle: advance to the falling edge and service the core model (READ_LAT=1).
  task automatic tick();
    @(negedge clk3);
    if (read === 1'b1) begin
      read_cnt++;
      if (pending.size() > 0) sum = pending.pop_front();
    end
    empty = (pending.size() == 0);
  endtask

  task automatic push(input logic [31:0] s, input logic [15:0] e);
    pending.push_back(s);
    exp_q.push_back(e);
    empty = 1'b0;
  endtask

  task automatic wait_count(input logic [15:0] target, input int budget, input string name);
    int i = 0;
    while (result_count !== target && i < budget) begin
      tick();
      i++;
    end
    check(name, 32'(result_count), 32'(target));
  endtask

  task automatic monitor();
    logic        hold = 1'b0;
    logic [15:0] held = '0;
    logic [15:0] e;
    forever begin
      @(negedge clk3);
      #2;
      if (hold && out_valid) check("hold_stable", 32'(out_data), 32'(held));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got %0h, expected no result", out_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", 32'(out_data), 32'(e));
        end
      end
      hold = out_valid && !out_ready;
      held = out_data;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    empty = 1'b1;
    sum = '0;
    out_ready = 1'b0;
    fork
      monitor();
    join_none

    // Reset held with an empty core.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_read", 32'(read), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
    end
    check("rst_count", 32'(result_count), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (3) tick();
    check("idle_no_read", 32'(read_cnt), 32'd0);

    // Basic latency: empty low in j, read in j+1, valid in j+3.
    out_ready = 1'b1;
    push(32'd256000, 16'd1000);
    tick();
    check("t2_read_j1", 32'(read), 32'd1);
    tick();
    check("t2_read_j2", 32'(read), 32'd0);
    check("t2_valid_j2", 32'(out_valid), 32'd0);
    tick();
    check("t2_valid_j3", 32'(out_valid), 32'd1);
    check("t2_data_j3", 32'(out_data), 32'd1000);
    tick();
    check("t2_valid_j4", 32'(out_valid), 32'd0);
    check("t2_count", 32'(result_count), 32'd1);
    check("t2_reads", 32'(read_cnt), 32'd1);
    check("t2_sat", 32'(sat_flag), 32'd0);

    // Saturation, then a negative in-range value.
    push(32'h7FFF_FFFF, 16'h7FFF);
    wait_count(16'd2, 20, "t3_count_a");
    check("t3_sat_set", 32'(sat_flag), 32'd1);
    push(32'hFFFF_F600, 16'hFFF6);
    wait_count(16'd3, 20, "t3_count_b");
    check("t3_sat_sticky", 32'(sat_flag), 32'd1);

    // Truncate vs round half up.
`ifdef FIR_READER_ROUND_EN
    push(32'd384, 16'd2);
`else
    push(32'd384, 16'd1);
`endif
    wait_count(16'd4, 20, "t4_count");

    // Back-pressure: one pop while held, next pop one cycle after the accept.
    out_ready = 1'b0;
    r0 = read_cnt;
    push(32'd1280, 16'd5);
    push(32'd2560, 16'd10);
    repeat (9) tick();
    check("t5_single_read", 32'(read_cnt - r0), 32'd1);
    check("t5_held_valid", 32'(out_valid), 32'd1);
    check("t5_held_data", 32'(out_data), 32'd5);
    out_ready = 1'b1;
    tick();
    check("t5_idle_read", 32'(read), 32'd0);
    check("t5_idle_valid", 32'(out_valid), 32'd0);
    check("t5_count_a", 32'(result_count), 32'd5);
    tick();
    check("t5_next_read", 32'(read), 32'd1);
    wait_count(16'd6, 20, "t5_count_b");

    // Sixteen queued results, mixed sign.
    r0 = read_cnt;
    for (int i = 0; i < 16; i++) push(32'((i - 8) * 256 + 100), 16'(i - 8));
    wait_count(16'd22, 200, "t5_burst_count");
    check("t5_burst_reads", 32'(read_cnt - r0), 32'd16);

    // Reset during WAIT discards the in-flight result.
    push(32'd2560, 16'd10);
    tick();
    check("t6_read", 32'(read), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("t6_rst_read", 32'(read), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_count", 32'(result_count), 32'd0);
    check("t6_rst_sat", 32'(sat_flag), 32'd0);
    void'(exp_q.pop_back());
    reset = 1'b0;
    push(32'd512, 16'd2);
    wait_count(16'd1, 20, "t6_count");
    check("t6_sat_clear", 32'(sat_flag), 32'd0);

    repeat (4) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
